button_event_unit: RTL and testbench

Converts the debounced button levels into discrete, timestamp-free input events for the game controller: press, long-press, auto-repeat and release. It sits directly downstream of the debouncers, one input bit per debounced button. It queues at most one pending event per button per kind and presents them one at a time on a valid/ready port. The game FSM consumes that port to move the cursor and place pieces.

---
 rtl/button_event_pkg.sv | 42 ++++
 rtl/button_event_unit_btn_tracker.sv | 111 +++++++++++
 rtl/button_event_unit.sv | 153 +++++++++++++++
 tb/tb_button_event_unit.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/button_event_pkg.sv
// ---------------------------------------------------------------------------
// button_event_pkg
//
// Shared types for the button event unit: the event kind codes presented on
// the consumer port, and the per-button tracker states.
// Also provides a small helper that picks the lowest pending kind code
// from a button's pending-bit vector.
// ---------------------------------------------------------------------------
package button_event_pkg;

    // Event kind codes; the numeric value doubles as the pending-bit index
    // and as the within-button priority (lowest code served first).
    typedef enum logic [1:0] {
        PRESS   = 2'd0,
        LONG    = 2'd1,
        REPEAT  = 2'd2,
        RELEASE = 2'd3
    } ev_kind_e;

    // Per-button tracker states.
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        PRESSED   = 2'd1,
        REPEATING = 2'd2
    } btn_state_e;

    localparam int NUM_KINDS = 4;

    // Returns the index of the lowest set bit (0 when none is set; callers
    // only use the result when at least one bit is set).
    function automatic logic [1:0] lowestKind(input logic [NUM_KINDS-1:0] bits);
        logic [1:0] kind;
        kind = 2'd0;
        for (int j = NUM_KINDS - 1; j >= 0; j--) begin
            if (bits[j]) begin
                kind = 2'(j);
            end
        end
        return kind;
    endfunction

endpackage

// File: rtl/button_event_unit_btn_tracker.sv
// ---------------------------------------------------------------------------
// btn_tracker
//
// Tracks one debounced button: keeps the previous level for edge detection,
// runs the IDLE/PRESSED/REPEATING state machine with its hold counter, and
// emits one-cycle raise strobes for PRESS, LONG, REPEAT and RELEASE.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   level_i      debounced button level, 1 = pressed
//   held_o       registered copy of level_i (the previous level)
//   pressEv_o    PRESS raised this cycle
//   longEv_o     LONG raised this cycle
//   repeatEv_o   REPEAT raised this cycle
//   releaseEv_o  RELEASE raised this cycle
// ---------------------------------------------------------------------------
module btn_tracker
    import button_event_pkg::*;
#(
    parameter int LONG_CYCLES   = 50_000_000,
    parameter int REPEAT_CYCLES = 10_000_000,
    parameter int CNT_W         = 26
) (
    input  logic clk,
    input  logic reset,
    input  logic level_i,
    output logic held_o,
    output logic pressEv_o,
    output logic longEv_o,
    output logic repeatEv_o,
    output logic releaseEv_o
);

    localparam logic [CNT_W-1:0] LONG_LAST   = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             prev_q;
    logic             riseEdge;
    logic             fallEdge;

    assign riseEdge = level_i & ~prev_q;
    assign fallEdge = ~level_i & prev_q;
    assign held_o   = prev_q;

    // State, hold counter and previous level. Clearing prev on reset means a
    // button still held when reset drops is seen as a fresh press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            prev_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prev_q  <= level_i;
        end
    end

    // Next-state and strobe logic. A falling edge wins over everything, so a
    // LONG or REPEAT landing on the release cycle is suppressed. The counter
    // is cleared at each terminal count and therefore never wraps.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        pressEv_o   = 1'b0;
        longEv_o    = 1'b0;
        repeatEv_o  = 1'b0;
        releaseEv_o = 1'b0;

        if (fallEdge) begin
            releaseEv_o = 1'b1;
            cnt_d       = '0;
            state_d     = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (riseEdge) begin
                        pressEv_o = 1'b1;
                        cnt_d     = '0;
                        state_d   = PRESSED;
                    end
                end
                PRESSED: begin
                    if (cnt_q == LONG_LAST) begin
                        longEv_o = 1'b1;
                        cnt_d    = '0;
                        state_d  = REPEATING;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                REPEATING: begin
                    if (cnt_q == REPEAT_LAST) begin
                        repeatEv_o = 1'b1;
                        cnt_d      = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

endmodule

// File: rtl/button_event_unit.sv
// ---------------------------------------------------------------------------
// button_event_unit
//
// Turns debounced button levels into PRESS / LONG / REPEAT / RELEASE events
// for the game controller. Each button/kind pair can hold one pending event;
// pending events are handed out one at a time through a valid/ready port,
// buttons served round-robin, lowest kind code first within a button.
//
// Ports:
//   clk          clock
//   reset        asynchronous, active-high reset
//   btn_level_i  debounced button levels, 1 = pressed
//   ev_valid_o   an event is presented
//   ev_ready_i   consumer takes the presented event this cycle
//   ev_btn_o     button index of the presented event
//   ev_kind_o    kind of the presented event (0 PRESS .. 3 RELEASE)
//   held_o       registered copy of btn_level_i
//   overflow_o   sticky: at least one event was dropped
// ---------------------------------------------------------------------------
module button_event_unit
    import button_event_pkg::*;
#(
    parameter int    NUM_BTN       = 5,
    parameter int    LONG_CYCLES   = 50_000_000,
    parameter int    REPEAT_CYCLES = 10_000_000,
    parameter int    CNT_W         = 26,
    localparam int   BTN_W         = (NUM_BTN > 1) ? $clog2(NUM_BTN) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [NUM_BTN-1:0] btn_level_i,
    output logic               ev_valid_o,
    input  logic               ev_ready_i,
    output logic [BTN_W-1:0]   ev_btn_o,
    output logic [1:0]         ev_kind_o,
    output logic [NUM_BTN-1:0] held_o,
    output logic               overflow_o
);

    localparam int               IDX_W     = BTN_W + 1;
    localparam logic [IDX_W-1:0] NUM_BTN_X = IDX_W'(NUM_BTN);
    localparam logic [BTN_W-1:0] LAST_BTN  = BTN_W'(NUM_BTN - 1);

    logic [NUM_BTN-1:0][NUM_KINDS-1:0] setVec;
    logic [NUM_BTN-1:0][NUM_KINDS-1:0] clrVec;
    logic [NUM_BTN-1:0][NUM_KINDS-1:0] pend_q, pend_d;

    logic [BTN_W-1:0] rrPtr_q, rrPtr_d;
    logic             evValid_q, evValid_d;
    logic [BTN_W-1:0] evBtn_q, evBtn_d;
    ev_kind_e         evKind_q, evKind_d;
    logic             overflow_q, overflow_d;

    logic             loadEn;
    logic             grantFound;
    logic [BTN_W-1:0] grantBtn;
    ev_kind_e         grantKind;
    logic [IDX_W-1:0] scanIdx;
    logic             dropHit;

    // One tracker per button; its four strobes land in that button's row of
    // setVec, ordered by kind code.
    for (genvar b = 0; b < NUM_BTN; b++) begin : gTrk
        btn_tracker #(
            .LONG_CYCLES   (LONG_CYCLES),
            .REPEAT_CYCLES (REPEAT_CYCLES),
            .CNT_W         (CNT_W)
        ) uTracker (
            .clk         (clk),
            .reset       (reset),
            .level_i     (btn_level_i[b]),
            .held_o      (held_o[b]),
            .pressEv_o   (setVec[b][PRESS]),
            .longEv_o    (setVec[b][LONG]),
            .repeatEv_o  (setVec[b][REPEAT]),
            .releaseEv_o (setVec[b][RELEASE])
        );
    end

    // Round-robin search starting at rrPtr_q (the button after the last one
    // granted). The index is wrapped by hand so NUM_BTN need not be a power
    // of two.
    always_comb begin
        grantFound = 1'b0;
        grantBtn   = '0;
        grantKind  = PRESS;
        scanIdx    = '0;
        for (int i = 0; i < NUM_BTN; i++) begin
            scanIdx = {1'b0, rrPtr_q} + IDX_W'(i);
            if (scanIdx >= NUM_BTN_X) begin
                scanIdx = scanIdx - NUM_BTN_X;
            end
            if (!grantFound && (pend_q[scanIdx[BTN_W-1:0]] != '0)) begin
                grantFound = 1'b1;
                grantBtn   = scanIdx[BTN_W-1:0];
                grantKind  = ev_kind_e'(lowestKind(pend_q[scanIdx[BTN_W-1:0]]));
            end
        end
    end

    // Output register reload, pending-bit update and overflow detection.
    // A bit granted and re-raised in the same cycle stays set: the grant
    // takes the old event and the new one takes its place, so nothing is
    // lost and no overflow is flagged.
    always_comb begin
        loadEn     = ~evValid_q | ev_ready_i;
        clrVec     = '0;
        evValid_d  = evValid_q;
        evBtn_d    = evBtn_q;
        evKind_d   = evKind_q;
        rrPtr_d    = rrPtr_q;

        if (loadEn) begin
            evValid_d = grantFound;
            if (grantFound) begin
                clrVec[grantBtn][grantKind] = 1'b1;
                evBtn_d  = grantBtn;
                evKind_d = grantKind;
                rrPtr_d  = (grantBtn == LAST_BTN) ? '0 : grantBtn + 1'b1;
            end
        end

        dropHit    = |(setVec & pend_q & ~clrVec);
        pend_d     = (pend_q & ~clrVec) | setVec;
        overflow_d = overflow_q | dropHit;
    end

    // All arbitration and output state; reset discards every pending and
    // presented event at once.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q     <= '0;
            rrPtr_q    <= '0;
            evValid_q  <= 1'b0;
            evBtn_q    <= '0;
            evKind_q   <= PRESS;
            overflow_q <= 1'b0;
        end else begin
            pend_q     <= pend_d;
            rrPtr_q    <= rrPtr_d;
            evValid_q  <= evValid_d;
            evBtn_q    <= evBtn_d;
            evKind_q   <= evKind_d;
            overflow_q <= overflow_d;
        end
    end

    assign ev_valid_o = evValid_q;
    assign ev_btn_o   = evBtn_q;
    assign ev_kind_o  = evKind_q;
    assign overflow_o = overflow_q;

endmodule

// File: tb/tb_button_event_unit.sv
// ---------------------------------------------------------------------------
// tb_button_event_unit
//
// Directed bench for button_event_unit with short hold times (LONG=8,
// REPEAT=4). Every accepted event is logged with the cycle it was presented
// on, and the log is compared against hand-computed expectations.
// ---------------------------------------------------------------------------
module tb_button_event_unit;
    import button_event_pkg::*;

    localparam int NB = 5;
    localparam int LC = 8;
    localparam int RC = 4;
    localparam int CW = 5;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [NB-1:0] btnLevel = '0;
    logic          evReady = 1'b0;
    logic          evValid;
    logic [2:0]    evBtn;
    logic [1:0]    evKind;
    logic [NB-1:0] held;
    logic          overflow;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int logCyc[$];
    int logBtn[$];
    int logKind[$];

    button_event_unit #(
        .NUM_BTN       (NB),
        .LONG_CYCLES   (LC),
        .REPEAT_CYCLES (RC),
        .CNT_W         (CW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_level_i (btnLevel),
        .ev_valid_o  (evValid),
        .ev_ready_i  (evReady),
        .ev_btn_o    (evBtn),
        .ev_kind_o   (evKind),
        .held_o      (held),
        .overflow_o  (overflow)
    );

    // Free-running clock and cycle counter.
    always #5 clk = ~clk;

    always @(posedge clk) begin
        cyc <= cyc + 1;
    end

    // Log every handshake, sampled on the falling edge before the accepting
    // rising edge.
    always @(negedge clk) begin
        if (!reset && evValid && evReady) begin
            logCyc.push_back(cyc);
            logBtn.push_back(int'(evBtn));
            logKind.push_back(int'(evKind));
        end
    end

    task automatic checkOutput(input string tag, input int observed, input int expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Drive levels and ready just after an edge, then let n edges pass.
    task automatic applyStimulus(input logic [NB-1:0] lvl, input logic rdy, input int n);
        btnLevel = lvl;
        evReady  = rdy;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic checkEvent(input string tag, input int i, input int c, input int b, input int k);
        if (i < logCyc.size()) begin
            checkOutput({tag, ".cyc"}, logCyc[i], c);
            checkOutput({tag, ".btn"}, logBtn[i], b);
            checkOutput({tag, ".kind"}, logKind[i], k);
        end else begin
            checkOutput({tag, ".present"}, logCyc.size(), i + 1);
        end
    endtask

    task automatic clearLog();
        logCyc.delete();
        logBtn.delete();
        logKind.delete();
    endtask

    initial begin
        int t0, t1, t2, t3, t4;

        // Reset values
        #1;
        applyStimulus('0, 1'b0, 3);
        checkOutput("rst.valid", int'(evValid), 0);
        checkOutput("rst.btn", int'(evBtn), 0);
        checkOutput("rst.kind", int'(evKind), 0);
        checkOutput("rst.held", int'(held), 0);
        checkOutput("rst.overflow", int'(overflow), 0);
        reset = 1'b0;
        applyStimulus('0, 1'b1, 3);

        // Short press of button 2: PRESS then RELEASE, no LONG
        clearLog();
        t0 = cyc;
        applyStimulus(5'b00100, 1'b1, 5);
        checkOutput("t1.held", int'(held), 5'b00100);
        t1 = cyc;
        applyStimulus('0, 1'b1, 6);
        checkOutput("t1.count", logCyc.size(), 2);
        checkEvent("t1.press", 0, t0 + 2, 2, int'(PRESS));
        checkEvent("t1.release", 1, t1 + 2, 2, int'(RELEASE));

        // Hold button 0 for 30 cycles: PRESS, LONG, five REPEATs, RELEASE
        clearLog();
        t0 = cyc;
        applyStimulus(5'b00001, 1'b1, 30);
        applyStimulus('0, 1'b1, 12);
        checkOutput("t2.count", logCyc.size(), 8);
        checkEvent("t2.press", 0, t0 + 2, 0, int'(PRESS));
        checkEvent("t2.long", 1, t0 + 10, 0, int'(LONG));
        for (int r = 0; r < 5; r++) begin
            checkEvent($sformatf("t2.repeat%0d", r), 2 + r, t0 + 14 + 4 * r, 0, int'(REPEAT));
        end
        checkEvent("t2.release", 7, t0 + 32, 0, int'(RELEASE));

        // Release on the exact cycle LONG would fire: LONG suppressed
        clearLog();
        t0 = cyc;
        applyStimulus(5'b00001, 1'b1, LC);
        applyStimulus('0, 1'b1, 12);
        checkOutput("t2b.count", logCyc.size(), 2);
        checkEvent("t2b.press", 0, t0 + 2, 0, int'(PRESS));
        checkEvent("t2b.release", 1, t0 + LC + 2, 0, int'(RELEASE));

        // Simultaneous presses of buttons 1 and 3, then again with rotated order
        clearLog();
        t0 = cyc;
        applyStimulus(5'b01010, 1'b1, 4);
        t1 = cyc;
        applyStimulus(5'b00010, 1'b1, 4);
        t2 = cyc;
        applyStimulus('0, 1'b1, 4);
        t3 = cyc;
        applyStimulus(5'b01010, 1'b1, 4);
        t4 = cyc;
        applyStimulus('0, 1'b1, 4);
        checkOutput("t3.count", logCyc.size(), 8);
        checkEvent("t3.pressA1", 0, t0 + 2, 1, int'(PRESS));
        checkEvent("t3.pressA3", 1, t0 + 3, 3, int'(PRESS));
        checkEvent("t3.rel3", 2, t1 + 2, 3, int'(RELEASE));
        checkEvent("t3.rel1", 3, t2 + 2, 1, int'(RELEASE));
        checkEvent("t3.pressB3", 4, t3 + 2, 3, int'(PRESS));
        checkEvent("t3.pressB1", 5, t3 + 3, 1, int'(PRESS));
        checkEvent("t3.relB3", 6, t4 + 2, 3, int'(RELEASE));
        checkEvent("t3.relB1", 7, t4 + 3, 1, int'(RELEASE));

        // Backpressure: btn 0 occupies the output while btn 4 toggles twice
        clearLog();
        t0 = cyc;
        applyStimulus(5'b00001, 1'b0, 2);
        applyStimulus(5'b10001, 1'b0, 1);
        checkOutput("t4.validEarly", int'(evValid), 1);
        checkOutput("t4.btnEarly", int'(evBtn), 0);
        checkOutput("t4.kindEarly", int'(evKind), int'(PRESS));
        applyStimulus(5'b00001, 1'b0, 1);
        checkOutput("t4.noOverflowYet", int'(overflow), 0);
        applyStimulus(5'b10001, 1'b0, 1);
        applyStimulus(5'b00001, 1'b0, 2);
        checkOutput("t4.validHeld", int'(evValid), 1);
        checkOutput("t4.btnHeld", int'(evBtn), 0);
        checkOutput("t4.kindHeld", int'(evKind), int'(PRESS));
        checkOutput("t4.overflow", int'(overflow), 1);
        checkOutput("t4.count0", logCyc.size(), 0);
        applyStimulus('0, 1'b1, 8);
        checkOutput("t4.count", logCyc.size(), 4);
        checkEvent("t4.press0", 0, t0 + 7, 0, int'(PRESS));
        checkEvent("t4.press4", 1, t0 + 8, 4, int'(PRESS));
        checkEvent("t4.release0", 2, t0 + 9, 0, int'(RELEASE));
        checkEvent("t4.release4", 3, t0 + 10, 4, int'(RELEASE));
        checkOutput("t4.validEnd", int'(evValid), 0);

        // Reset while btn 0 is repeating and the level stays high
        clearLog();
        applyStimulus(5'b00001, 1'b0, 12);
        checkOutput("t5.validBefore", int'(evValid), 1);
        reset = 1'b1;
        applyStimulus(5'b00001, 1'b0, 1);
        checkOutput("t5.valid", int'(evValid), 0);
        checkOutput("t5.btn", int'(evBtn), 0);
        checkOutput("t5.kind", int'(evKind), 0);
        checkOutput("t5.held", int'(held), 0);
        checkOutput("t5.overflow", int'(overflow), 0);
        reset = 1'b0;
        t0 = cyc;
        applyStimulus(5'b00001, 1'b1, 8);
        checkOutput("t5.count", logCyc.size(), 1);
        checkEvent("t5.press", 0, t0 + 2, 0, int'(PRESS));
        applyStimulus('0, 1'b1, 4);

        // Reset while repeating, level dropped during reset: nothing follows
        clearLog();
        applyStimulus(5'b00001, 1'b0, 12);
        reset = 1'b1;
        applyStimulus('0, 1'b0, 2);
        reset = 1'b0;
        applyStimulus('0, 1'b1, 10);
        checkOutput("t5b.count", logCyc.size(), 0);
        checkOutput("t5b.valid", int'(evValid), 0);
        checkOutput("t5b.overflow", int'(overflow), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
